// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency-measurement controller.
package freq_counter_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COUNT   = 3'd1,
      TENS    = 3'd2,
      UNITS   = 3'd3,
      PUBLISH = 3'd4
   } state_t;

   localparam int unsigned MAX_COUNT = 99;
   localparam int unsigned BCD_W     = 4;
   localparam int unsigned COUNT_W   = 7;
endpackage

// File: rtl/freq_meas_sequencer_gate_timer.sv
// Gate-window down-counter: loads max(period,2)-1 and flags the final window cycle.
module gate_timer #(
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                load_i,
   input  logic                run_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                last_cycle_o
);
   logic [PERIOD_W-1:0] timer_q, timer_d, load_val;

   always_comb begin
      // periods of 0 and 1 clamp to a two-cycle window
      load_val = (period_i < PERIOD_W'(2)) ? PERIOD_W'(1) : period_i - PERIOD_W'(1);
      timer_d  = timer_q;
      if (load_i)
         timer_d = load_val;
      else if (run_i && (timer_q != '0))
         timer_d = timer_q - PERIOD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstb)
         timer_q <= '0;
      else
         timer_q <= timer_d;
   end

   assign last_cycle_o = (timer_q == '0);
endmodule

// File: rtl/freq_meas_sequencer.sv
// Frequency-measurement controller: gate window, edge count, BCD conversion, result handshake.
//
// state   | meaning
// IDLE    | waiting for enable
// COUNT   | gate open, counting edge pulses
// TENS    | repeated subtraction of 10 from the count
// UNITS   | capture remainder as units digit
// PUBLISH | load result outputs, raise result_valid
module freq_meas_sequencer #(
   parameter int unsigned PERIOD_W  = 16,
   parameter int unsigned MAX_COUNT = freq_counter_pkg::MAX_COUNT
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                edge_pulse,
   input  logic                result_ready,
   input  logic                overrun_clr,
   output logic                gate,
   output logic                busy,
   output logic                result_valid,
   output logic [3:0]          tens,
   output logic [3:0]          units,
   output logic                sat,
   output logic                overrun
);
   import freq_counter_pkg::*;

   localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);
   localparam logic [COUNT_W:0]   MAX_X = (COUNT_W+1)'(MAX_COUNT);

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d, work_q, work_d;
   logic [BCD_W-1:0]   tens_int_q, tens_int_d, units_int_q, units_int_d;
   logic [BCD_W-1:0]   tens_q, tens_d, units_q, units_d;
   logic               sat_int_q, sat_int_d, sat_q, sat_d;
   logic               valid_q, valid_d, overrun_q, overrun_d;
   logic               timer_load, last_cycle;
   logic [COUNT_W:0]   cnt_plus;

   gate_timer #(.PERIOD_W(PERIOD_W)) u_gate_timer (
      .clk          (clk),
      .rstb         (rstb),
      .load_i       (timer_load),
      .run_i        (state_q == COUNT),
      .period_i     (period),
      .last_cycle_o (last_cycle)
   );

   assign cnt_plus = {1'b0, edge_cnt_q} + {{COUNT_W{1'b0}}, 1'b1};

   always_comb begin
      state_d     = state_q;
      edge_cnt_d  = edge_cnt_q;
      work_d      = work_q;
      tens_int_d  = tens_int_q;
      units_int_d = units_int_q;
      sat_int_d   = sat_int_q;
      tens_d      = tens_q;
      units_d     = units_q;
      sat_d       = sat_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      timer_load  = 1'b0;

      if (valid_q && result_ready) valid_d = 1'b0;
      if (overrun_clr)             overrun_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = COUNT;
               timer_load = 1'b1;
               edge_cnt_d = '0;
               sat_int_d  = 1'b0;
            end
         end
         COUNT: begin
            if (edge_pulse) begin
               if (cnt_plus >= MAX_X) begin
                  edge_cnt_d = MAX_C;
                  sat_int_d  = 1'b1;
               end else begin
                  edge_cnt_d = cnt_plus[COUNT_W-1:0];
               end
            end
            if (!enable) begin
               state_d = IDLE;
            end else if (last_cycle) begin
               state_d    = TENS;
               work_d     = edge_cnt_d;
               tens_int_d = '0;
            end
         end
         TENS: begin
            if (work_q >= COUNT_W'(10)) begin
               work_d     = work_q - COUNT_W'(10);
               tens_int_d = tens_int_q + BCD_W'(1);
            end else begin
               state_d = UNITS;
            end
         end
         UNITS: begin
            units_int_d = work_q[BCD_W-1:0];
            state_d     = PUBLISH;
         end
         PUBLISH: begin
            tens_d  = tens_int_q;
            units_d = units_int_q;
            sat_d   = sat_int_q;
            // a same-edge accept counts as taken, so only an unread result is an overrun
            if (valid_q && !result_ready) overrun_d = 1'b1;
            valid_d = 1'b1;
            if (enable) begin
               state_d    = COUNT;
               timer_load = 1'b1;
               edge_cnt_d = '0;
               sat_int_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= IDLE;
         edge_cnt_q  <= '0;
         work_q      <= '0;
         tens_int_q  <= '0;
         units_int_q <= '0;
         sat_int_q   <= 1'b0;
         tens_q      <= '0;
         units_q     <= '0;
         sat_q       <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         edge_cnt_q  <= edge_cnt_d;
         work_q      <= work_d;
         tens_int_q  <= tens_int_d;
         units_int_q <= units_int_d;
         sat_int_q   <= sat_int_d;
         tens_q      <= tens_d;
         units_q     <= units_d;
         sat_q       <= sat_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign gate         = (state_q == COUNT);
   assign busy         = (state_q != IDLE);
   assign result_valid = valid_q;
   assign tens         = tens_q;
   assign units        = units_q;
   assign sat          = sat_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Scoreboard bench for freq_meas_sequencer: windows push expected BCD results, publishes pop them.
module tb_freq_meas_sequencer;
   logic        clk = 1'b0;
   logic        rstb, enable, edge_pulse, result_ready, overrun_clr;
   logic [15:0] period;
   logic        gate, busy, result_valid, sat, overrun;
   logic [3:0]  tens, units;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] u;
      logic       s;
   } res_t;
   res_t sb[$];

   always #5 clk = ~clk;

   freq_meas_sequencer #(.PERIOD_W(16), .MAX_COUNT(99)) dut (
      .clk          (clk),
      .rstb         (rstb),
      .enable       (enable),
      .period       (period),
      .edge_pulse   (edge_pulse),
      .result_ready (result_ready),
      .overrun_clr  (overrun_clr),
      .gate         (gate),
      .busy         (busy),
      .result_valid (result_valid),
      .tens         (tens),
      .units        (units),
      .sat          (sat),
      .overrun      (overrun)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input int n);
      res_t r;
      int   c;
      c   = (n > 99) ? 99 : n;
      r.t = 4'(c / 10);
      r.u = 4'(c % 10);
      r.s = (n >= 99);
      sb.push_back(r);
   endtask

   // Called at a negedge; returns at the first negedge after the gate closes.
   task automatic do_window(input int per, input int n, input bit last_edge, input string nm);
      int pe, i, budget;
      pe     = (per < 2) ? 2 : per;
      period = 16'(per);
      enable = 1'b1;
      budget = 0;
      while (!gate && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (gate !== 1'b1) begin
         errors++;
         $display("FAIL %s gate_start: gate=%b required 1", nm, gate);
      end
      i = 0;
      while (gate && i < 1000) begin
         edge_pulse = (i < (n - int'(last_edge))) || (last_edge && (i == pe - 1));
         i++;
         @(negedge clk);
      end
      edge_pulse = 1'b0;
      checks++;
      if (i != pe) begin
         errors++;
         $display("FAIL %s gate_len: cycles=%0d required %0d", nm, i, pe);
      end
      push_exp(n);
   endtask

   // Called at the first non-gate negedge; edges are driven during conversion and must be ignored.
   task automatic check_result(input bit prior_valid, input string nm);
      res_t r;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: queue empty, required one entry", nm);
         return;
      end
      r = sb.pop_front();
      edge_pulse = 1'b1;
      repeat (int'(r.t) + 2) @(negedge clk);
      if (!prior_valid) begin
         checks++;
         if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid: result_valid=%b required 0", nm, result_valid);
         end
      end
      @(negedge clk);
      edge_pulse = 1'b0;
      checks++;
      if (result_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s latency: result_valid=%b required 1", nm, result_valid);
      end
      checks++;
      if ({tens, units, sat} !== {r.t, r.u, r.s}) begin
         errors++;
         $display("FAIL %s data: tens=%0d units=%0d sat=%b required tens=%0d units=%0d sat=%b",
                  nm, tens, units, sat, r.t, r.u, r.s);
      end
   endtask

   task automatic wait_idle(input string nm);
      int budget;
      enable = 1'b0;
      budget = 0;
      @(negedge clk);
      while (busy && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle: busy=%b required 0", nm, busy);
      end
   endtask

   task automatic check_all_zero(input string nm);
      checks++;
      if ({gate, busy, result_valid, tens, units, sat, overrun} !== 13'b0) begin
         errors++;
         $display("FAIL %s zero_outputs: gate=%b busy=%b valid=%b tens=%0d units=%0d sat=%b overrun=%b required all 0",
                  nm, gate, busy, result_valid, tens, units, sat, overrun);
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0; enable = 1'b0; edge_pulse = 1'b0;
      result_ready = 1'b1; overrun_clr = 1'b0; period = 16'd10;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_window(10, 7, 1'b0, "basic_7");
      check_result(1'b0, "basic_7");
      wait_idle("basic");
      do_window(100, 42, 1'b1, "final_edge_42");
      check_result(1'b0, "final_edge_42");
      wait_idle("final_edge");
   endtask

   task automatic test_saturation();
      do_window(200, 150, 1'b0, "sat_150");
      check_result(1'b0, "sat_150");
      wait_idle("sat_150");
      do_window(120, 99, 1'b1, "sat_99");
      check_result(1'b0, "sat_99");
      do_window(120, 98, 1'b0, "sat_98");
      check_result(1'b0, "sat_98");
      wait_idle("sat_98");
      do_window(0, 1, 1'b0, "period_0");
      check_result(1'b0, "period_0");
      wait_idle("period_0");
   endtask

   task automatic test_back_to_back();
      result_ready = 1'b0;
      do_window(10, 3, 1'b0, "b2b_first");
      check_result(1'b0, "b2b_first");
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first overrun: overrun=%b required 0", overrun);
      end
      do_window(10, 5, 1'b0, "b2b_second");
      check_result(1'b1, "b2b_second");
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second overrun: overrun=%b required 1", overrun);
      end
      wait_idle("b2b");
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clr: overrun=%b required 0", overrun);
      end
      checks++;
      if (result_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_valid: result_valid=%b required 1", result_valid);
      end
      result_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("FAIL accept: result_valid=%b required 0", result_valid);
      end
   endtask

   task automatic test_abort();
      int budget;
      period = 16'd20;
      enable = 1'b1;
      budget = 0;
      while (!gate && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      for (int i = 0; i < 5; i++) begin
         edge_pulse = 1'b1;
         @(negedge clk);
      end
      edge_pulse = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if ({gate, busy, result_valid} !== 3'b000) begin
         errors++;
         $display("FAIL abort_state: gate=%b busy=%b valid=%b required 000", gate, busy, result_valid);
      end
      checks++;
      if ({tens, units} !== {4'd0, 4'd5}) begin
         errors++;
         $display("FAIL abort_hold: tens=%0d units=%0d required 0/5", tens, units);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_nopublish: result_valid=%b required 0", result_valid);
      end
      do_window(30, 25, 1'b0, "disable_in_tens");
      enable = 1'b0;
      check_result(1'b0, "disable_in_tens");
      checks++;
      if ({gate, busy} !== 2'b00) begin
         errors++;
         $display("FAIL disable_in_tens idle: gate=%b busy=%b required 00", gate, busy);
      end
   endtask

   task automatic test_reset_mid();
      res_t dropped;
      do_window(60, 57, 1'b0, "reset_mid");
      dropped = sb.pop_front();
      @(negedge clk);
      rstb = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid");
      rstb = 1'b1;
      do_window(10, 4, 1'b0, "after_reset");
      check_result(1'b0, "after_reset");
      wait_idle("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
